usart_tx_ctrl: RTL
==================

Name: usart_tx_ctrl

Overview:
Transmit sequencer for the 8-bit PISO shift register in the USART_Tx path. Accepts a parallel byte through a request/acknowledge handshake, loads it into the PISO, and paces PISO shifting at the baud rate. It drives the serial line as a framed character: start bit, LSB-first data from the PISO, optional parity, then stop bit(s). A single instance sits between the host-side byte source and the PISO/line driver.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per bit period; legal range is 2 and above.
DATA_BITS, 8, data bits per frame; must equal the PISO width.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity and 1 selects odd parity; used only when PARITY_EN=1.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
CLR  in  1  reset, synchronous, active-high.
TX_REQ  in  1  byte request; held by the requester until TX_ACK.
TX_DATA  in  DATA_BITS  byte to send; sampled only when the request is accepted.
TX_ACK  out  1  one-cycle pulse marking request acceptance.
BUSY  out  1  high from the acceptance cycle through the last stop-bit cycle.
DONE  out  1  one-cycle pulse after a frame completes.
PISO_D  out  DATA_BITS  parallel load data to the PISO; holds the latched byte.
PISO_LOAD  out  1  PISO parallel-load select; the PISO loads when PISO_LOAD=1 and PISO_CE=1.
PISO_CE  out  1  PISO clock enable; the PISO shifts when PISO_CE=1 and PISO_LOAD=0.
PISO_SER  in  1  PISO serial output; presents the current bit, LSB first.
TX  out  1  serial line, registered, idle high.

Behaviour:
- Reset: CLR=1 sampled on a rising edge. On the next cycle, TX=1 and BUSY=TX_ACK=DONE=PISO_LOAD=PISO_CE=0. PISO_D=0, state is IDLE, and baud counter, bit counter and parity register are all 0.
- Reset mid-frame: CLR aborts the frame at once. TX returns to 1 the next cycle, DONE is not pulsed and the byte is discarded.
- States: IDLE, START, DATA, PARITY, STOP. The baud counter cnt runs 0..CLKS_PER_BIT-1 within every bit. A bit boundary is the edge where cnt=CLKS_PER_BIT-1; cnt then wraps to 0.
- IDLE: TX=1 and BUSY=0. If TX_REQ=1 at an edge:
  - TX_DATA latches into PISO_D and the parity register.
  - Next cycle is the first START cycle: TX=0, BUSY=1, TX_ACK=1, PISO_LOAD=1, PISO_CE=1.
  - TX_ACK, PISO_LOAD and PISO_CE last that single cycle; the PISO loads on the following edge.
- START: lasts CLKS_PER_BIT cycles with TX=0. At its boundary, TX<=PISO_SER (D0), state goes to DATA and the bit index is 0.
- DATA: each bit lasts CLKS_PER_BIT cycles.
  - In the cnt=0 cycle of bit index i < DATA_BITS-1, PISO_CE=1 and PISO_LOAD=0, so exactly one shift occurs per bit.
  - At each boundary, TX<=PISO_SER (the next bit).
  - After bit DATA_BITS-1, TX takes the parity bit and state goes to PARITY if PARITY_EN=1; otherwise TX<=1 and state goes to STOP.
- PARITY: TX = XOR of the latched byte XOR PARITY_ODD, held for CLKS_PER_BIT cycles. Then TX<=1 and state goes to STOP.
- STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles. Then state returns to IDLE with BUSY=0 and DONE=1 for that first IDLE cycle.
- Frame timing: the DONE cycle is exactly (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles after the TX_ACK cycle.
- Back-to-back requests: TX_REQ held high through DONE is accepted at the DONE-cycle edge, so the next TX_ACK/start bit follows DONE by one cycle.
- Request while BUSY: ignored with no TX_ACK. TX_DATA changes after TX_ACK have no effect on the frame in flight.
- TX is a register output and changes only at bit boundaries, at frame start, or on CLR. It is glitch-free.
- PISO_D holds the latched byte until the next acceptance.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 and PARITY_EN=0 unless stated.
- Reset: CLR=1 for 2 cycles with TX_REQ=1 -> TX=1, BUSY=0, no TX_ACK during CLR; the first TX_ACK comes one cycle after CLR drops.
- Single byte 0x0A: TX_REQ pulse -> TX_ACK and PISO_LOAD for 1 cycle. TX sequence per 4-cycle bit is 0 | 0,1,0,1,0,0,0,0 | 1. PISO_CE pulses 1+7 times. DONE arrives 40 cycles after TX_ACK.
- Parity: PARITY_EN=1 with 0x0A -> parity bit 0; with PARITY_ODD=1 -> parity bit 1. DONE arrives 44 cycles after TX_ACK.
- Back-to-back: REQ held with 0xFF then 0x00 -> second TX_ACK one cycle after the first DONE. The line carries 0,11111111,1 then 0,00000000,1.
- Abort: CLR asserted mid-DATA at bit 3 -> TX=1 the next cycle and no DONE. A new request afterwards sends a clean full frame.
- Busy and stop bits: STOP_BITS=2 with TX_REQ toggled during a frame -> no extra TX_ACK, the stop phase is 8 cycles high, and DONE arrives 44 cycles after TX_ACK.

Source files
------------

// File: rtl/usart_tx_ctrl.sv
// usart_tx_ctrl: transmit sequencer for an external DATA_BITS-wide PISO.
// A byte is accepted through a TX_REQ/TX_ACK handshake and loaded into the
// PISO. PISO shifts are then paced at the baud rate, and TX carries a framed
// character: start bit, LSB-first data, optional parity, then stop bit(s).
//
// Ports:
//   CLK        system clock, rising edge
//   CLR        synchronous active-high reset
//   TX_REQ     byte request, held until TX_ACK
//   TX_DATA    byte to send, sampled on acceptance
//   TX_ACK     one-cycle acceptance pulse (first start-bit cycle)
//   BUSY       high from acceptance through the last stop-bit cycle
//   DONE       one-cycle pulse in the first idle cycle after a frame
//   PISO_D     parallel load data, holds the latched byte
//   PISO_LOAD  PISO parallel-load select
//   PISO_CE    PISO clock enable (load or shift)
//   PISO_SER   PISO serial output, current bit
//   TX         registered serial line, idle high
module usart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 TX_REQ,
  input  logic [DATA_BITS-1:0] TX_DATA,
  output logic                 TX_ACK,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [DATA_BITS-1:0] PISO_D,
  output logic                 PISO_LOAD,
  output logic                 PISO_CE,
  input  logic                 PISO_SER,
  output logic                 TX
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_n;    // data bit index, reused as stop-bit index
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 par_q, par_n;      // parity bit, fixed at acceptance
  logic                 tx_q, tx_n;
  logic                 done_q, done_n;
  logic                 boundary;
  logic                 first_cycle;

  assign boundary    = (cnt == CNT_LAST);
  // The only START cycle with cnt=0 is the cycle right after acceptance, so
  // the handshake and PISO load pulses decode directly from state and count.
  assign first_cycle = (state == ST_START) && (cnt == '0);

  assign TX_ACK    = first_cycle;
  assign PISO_LOAD = first_cycle;
  // One shift in the first cycle of every data bit except the last, so
  // PISO_SER already shows the next bit when the boundary samples it.
  assign PISO_CE   = first_cycle ||
                     ((state == ST_DATA) && (cnt == '0) && (bit_idx != BIT_LAST));
  assign BUSY      = (state != ST_IDLE);
  assign DONE      = done_q;
  assign PISO_D    = data_q;
  assign TX        = tx_q;

  // NOTE: every variable gets its hold value before the case statement, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    data_n  = data_q;
    par_n   = par_q;
    tx_n    = tx_q;
    done_n  = 1'b0;

    if (state != ST_IDLE) begin
      cnt_n = boundary ? '0 : cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (TX_REQ) begin
          state_n = ST_START;
          cnt_n   = '0;
          tx_n    = 1'b0;
          data_n  = TX_DATA;
          par_n   = (^TX_DATA) ^ PAR_ODD;
        end
      end
      ST_START: begin
        if (boundary) begin
          tx_n    = PISO_SER;
          state_n = ST_DATA;
          bit_n   = '0;
        end
      end
      ST_DATA: begin
        if (boundary) begin
          if (bit_idx == BIT_LAST) begin
            bit_n = '0;
            if (PARITY_EN != 0) begin
              tx_n    = par_q;
              state_n = ST_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = ST_STOP;
            end
          end else begin
            tx_n  = PISO_SER;
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (boundary) begin
          tx_n    = 1'b1;
          state_n = ST_STOP;
          bit_n   = '0;
        end
      end
      ST_STOP: begin
        if (boundary) begin
          if (bit_idx == STOP_LAST) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            bit_n   = '0;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      data_q  <= data_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

endmodule
